mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//   Multi-cycle memory controller between the datapath's MAR/MDR and the
//   synchronous `ram` array. The control unit issues Read or write.
//   The block latches the address and data, adds WAIT_STATES cycles of access
//   latency and drives the single-cycle RAM write enable. It returns read data
//   to the MDR Mdatain input and gives the control unit busy/ready handshakes
//   so it can stall T-states.
// PARAMETERS
//   ADDR_W       9    address width; matches the MAR output
//   DATA_W       32   data word width
//   MEM_DEPTH    512  number of implemented words; addr >= MEM_DEPTH is an error
//   WAIT_STATES  1    extra cycles between RAM access and completion (0..15)
// PORTS
//   Clock      in   1       system clock, rising edge
//   Reset      in   1       asynchronous, active-low reset
//   Read       in   1       read request level from the control unit
//   write      in   1       write request level from the control unit
//   mar_addr   in   ADDR_W  address from MAR
//   mdr_data   in   DATA_W  write data from MDR
//   mem_rdata  out  DATA_W  read data to MDR Mdatain; held until the next read completes
//   mem_busy   out  1       high from request acceptance through the DONE cycle
//   mem_ready  out  1       one-cycle pulse when an access completes
//   mem_err    out  1       one-cycle pulse when a request is rejected
// BEHAVIOUR
//   Reset (async, Reset==0): state=IDLE, wait counter=0, latched address and
//     data=0. Outputs: mem_rdata=0, mem_busy=0, mem_ready=0, mem_err=0.
//     RAM we=0 immediately: it decodes from state, not from a registered flag.
//   FSM states: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
//   IDLE: on a rising edge with exactly one of Read/write high and
//     mar_addr < MEM_DEPTH:
//     - latch mar_addr, mdr_data and the operation type;
//     - go to ACCESS; mem_busy rises on the same edge.
//   IDLE rejects:
//     - Read and write both high -> mem_err pulses 1 cycle; no access; stay IDLE.
//     - mar_addr >= MEM_DEPTH -> mem_err pulses 1 cycle; no access; stay IDLE.
//   ACCESS: lasts exactly 1 cycle.
//     - RAM addr = latched address.
//     - RAM we = 1 only for a write, and only in this state.
//     - Load the counter with WAIT_STATES. Next state is WAIT, or DONE if WAIT_STATES==0.
//   WAIT: decrement the counter each cycle; go to DONE when it reaches 1.
//   DONE: lasts 1 cycle.
//     - mem_ready=1 and mem_busy=1.
//     - For a read, mem_rdata is loaded from RAM q on the entry edge, so it is
//       valid in the DONE cycle.
//     - Next state is IDLE.
//   Latency: accept edge -> mem_ready high after WAIT_STATES+2 cycles.
//     With WAIT_STATES=1, mem_ready is high in the third cycle after acceptance.
//   Read/write while busy: ignored; requests are not queued.
//     The control unit holds Read/write until mem_ready, then drops them.
//     A request still high in the cycle after DONE starts a new access.
//   mdr_data / mar_addr changes after acceptance: no effect on the access in flight.
//   Reset mid-operation: the access is abandoned.
//     - A write in ACCESS may or may not have committed.
//     - mem_rdata is cleared to 0.
//   Writes: mem_rdata is unchanged.
// STRUCTURE
//   Shared package (mem_pkg):
//     - state encodings IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3;
//     - WAIT counter width 4;
//     - MEM_DEPTH default.
//   Sub-module: the existing `ram` (data, addr, we, clk, q), instantiated once.
//   The FSM, counter and latches stay flat in mem_ctrl.
// TESTING
//   1. Write then read, WAIT_STATES=1:
//      write=1, addr=9'h054, mdr_data=32'h0000_0097 -> we=1 for 1 cycle,
//        mem_ready at accept+3.
//      Read addr=9'h054 -> mem_rdata=32'h0000_0097 in the DONE cycle.
//   2. Read and write both high, addr=9'h010 -> mem_err=1 for 1 cycle,
//      mem_busy stays 0, RAM contents at 9'h010 unchanged.
//   3. MEM_DEPTH=256, Read at addr=9'h1FF -> mem_err pulse, no access, mem_rdata unchanged.
//   4. Reset=0 asserted while in WAIT -> all outputs 0 within the same cycle, state=IDLE.
//      After release, a read of 9'h054 still completes normally.
//   5. WAIT_STATES=0: Read at 9'h000 -> mem_ready at accept+2.
//      Back-to-back reads of 9'h000 and 9'h001 -> two mem_ready pulses 3 cycles apart.
//   6. During an in-flight write, change mdr_data to 32'hDEAD_BEEF
//      -> RAM stores the originally latched value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory controller and its RAM.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int CNT_W         = 4;
  localparam int MEM_DEPTH_DEF = 512;

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM: registered read, single-cycle write enable.
module ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              clk,
  output logic [DATA_W-1:0] q
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_rng;

  assign idx    = addr[IDX_W-1:0];
  // Unimplemented addresses never get written, whatever the caller drives.
  assign in_rng = ({1'b0, addr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (we && in_rng) begin
      mem_q[idx] <= data;
    end
    q <= mem_q[idx];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle memory controller between MAR/MDR and the synchronous RAM,
// with wait-state timing and busy/ready/error handshakes to the control unit.
//
//   state  | meaning
//   IDLE   | waiting for exactly one of Read/write with a valid address
//   ACCESS | RAM addressed with the latched address; we asserted for writes
//   WAIT   | down-counting the configured wait states
//   DONE   | access complete: mem_ready pulse, read data valid
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              write,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_data,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] WS_LD     = CNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              addr_ok;
  logic              accept;
  logic              reject;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;

  assign addr_ok = ({1'b0, mar_addr} < DEPTH_LIM);
  assign accept  = (state_q == ST_IDLE) && (Read ^ write) && addr_ok;
  assign reject  = (state_q == ST_IDLE) && ((Read && write) || ((Read ^ write) && !addr_ok));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= OP_READ;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    err_d   = reject;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = mar_addr;
          data_d  = mdr_data;
          op_d    = write ? OP_WRITE : OP_READ;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d   = WS_LD;
        state_d = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // RAM q already holds the latched word by the edge that enters DONE.
    if ((state_d == ST_DONE) && (state_q != ST_DONE) && (op_q == OP_READ)) begin
      rdata_d = ram_q;
    end
  end

  // In IDLE the RAM is pointed at the incoming address so that q is valid
  // one cycle after acceptance, which zero-wait-state reads depend on.
  always_comb begin
    mem_busy  = (state_q != ST_IDLE);
    mem_ready = (state_q == ST_DONE);
    mem_err   = err_q;
    mem_rdata = rdata_q;
    ram_we    = (state_q == ST_ACCESS) && (op_q == OP_WRITE);
    ram_addr  = (state_q == ST_IDLE) ? mar_addr : addr_q;
  end

  ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .data (data_q),
    .addr (ram_addr),
    .we   (ram_we),
    .clk  (Clock),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (512 words / 1 wait state, 256 words / 0 wait
// states) checked against a transaction-level memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata_a, rdata_b;
  logic        busy_a, busy_b, ready_a, ready_b, err_a, err_b;
  logic [31:0] o_rdata;
  logic        o_busy, o_ready, o_err, o_we;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(9), .DATA_W(32), .MEM_DEPTH(512), .WAIT_STATES(1)) u_a (
    .Clock(clk), .Reset(rst_n), .Read(rd & ~sel), .write(wr & ~sel),
    .mar_addr(addr), .mdr_data(wdata), .mem_rdata(rdata_a),
    .mem_busy(busy_a), .mem_ready(ready_a), .mem_err(err_a)
  );

  mem_ctrl #(.ADDR_W(9), .DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_b (
    .Clock(clk), .Reset(rst_n), .Read(rd & sel), .write(wr & sel),
    .mar_addr(addr), .mdr_data(wdata), .mem_rdata(rdata_b),
    .mem_busy(busy_b), .mem_ready(ready_b), .mem_err(err_b)
  );

  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_ready = sel ? ready_b : ready_a;
  assign o_err   = sel ? err_b   : err_a;
  assign o_we    = sel ? u_b.ram_we : u_a.ram_we;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: memory contents and last read word per instance.
  logic [31:0] mdl_mem [2][512];
  logic [31:0] mdl_rdata [2];

  function automatic int ws_of(input bit s);
    return s ? 0 : 1;
  endfunction

  function automatic int depth_of(input bit s);
    return s ? 256 : 512;
  endfunction

  task automatic model_apply(input bit s, input bit r, input bit w, input logic [8:0] a,
                             input logic [31:0] d, output bit e_err,
                             output logic [31:0] e_rdata, output int e_lat, output int e_we);
    e_err = (r && w) || (int'(a) >= depth_of(s));
    e_lat = e_err ? 1 : ws_of(s) + 2;
    e_we  = (!e_err && w) ? 1 : 0;
    if (!e_err && w) mdl_mem[s][a] = d;
    if (!e_err && r) mdl_rdata[s] = mdl_mem[s][a];
    e_rdata = mdl_rdata[s];
  endtask

  // Issues one request, scrambles MAR/MDR right after the accept edge, and
  // returns what was observed up to completion plus one idle cycle.
  task automatic drive(input bit s, input bit r, input bit w, input logic [8:0] a,
                       input logic [31:0] d, output bit g_err, output logic [31:0] g_rdata,
                       output int g_lat, output int g_we, output bit busy_ok);
    @(negedge clk);
    sel = s; rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    addr = ~a;
    wdata = 32'hDEAD_BEEF;
    g_err = 1'b0; g_lat = -1; g_we = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (o_we) g_we++;
      if (o_err) begin
        g_err = 1'b1; g_lat = n;
        if (o_busy) busy_ok = 1'b0;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
      if (o_ready) begin
        g_lat = n;
        break;
      end
    end
    rd = 1'b0; wr = 1'b0;
    g_rdata = o_rdata;
    @(negedge clk);
    if (o_busy || o_ready || o_err) busy_ok = 1'b0;
  endtask

  task automatic run_op(input bit s, input bit r, input bit w, input logic [8:0] a,
                        input logic [31:0] d, input bit use_tbl, input bit t_err,
                        input logic [31:0] t_rdata);
    bit e_err, g_err, busy_ok;
    logic [31:0] e_rdata, g_rdata;
    int e_lat, e_we, g_lat, g_we;
    model_apply(s, r, w, a, d, e_err, e_rdata, e_lat, e_we);
    drive(s, r, w, a, d, g_err, g_rdata, g_lat, g_we, busy_ok);
    if (use_tbl) begin
      check($sformatf("tbl err s%0d a%h", s, a), 32'(g_err), 32'(t_err));
      check($sformatf("tbl rdata s%0d a%h", s, a), g_rdata, t_rdata);
    end else begin
      check($sformatf("err s%0d a%h", s, a), 32'(g_err), 32'(e_err));
      check($sformatf("rdata s%0d a%h", s, a), g_rdata, e_rdata);
    end
    check($sformatf("latency s%0d a%h", s, a), 32'(g_lat), 32'(e_lat));
    check($sformatf("we cycles s%0d a%h", s, a), 32'(g_we), 32'(e_we));
    check($sformatf("handshake s%0d a%h", s, a), 32'(busy_ok), 32'd1);
  endtask

  typedef struct {
    bit          s;
    bit          r;
    bit          w;
    logic [8:0]  a;
    logic [31:0] d;
    bit          x_err;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t1, t2;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;

    tbl.push_back('{1'b0, 1'b0, 1'b1, 9'h054, 32'h0000_0097, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 9'h054, 32'h0000_0000, 1'b0, 32'h0000_0097});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 9'h010, 32'h1111_1111, 1'b0, 32'h0000_0097});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 9'h010, 32'h2222_2222, 1'b1, 32'h0000_0097});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 9'h010, 32'h0000_0000, 1'b0, 32'h1111_1111});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 9'h1FF, 32'hCAFE_F00D, 1'b0, 32'h1111_1111});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0000_0000, 1'b0, 32'hCAFE_F00D});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 9'h000, 32'h0000_00A5, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 9'h001, 32'h0000_005A, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0000_0000, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 32'h0000_00A5});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0000_0000, 1'b1, 32'h0000_00A5});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 9'h0FF, 32'h0000_0077, 1'b0, 32'h0000_00A5});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 9'h100, 32'h0000_0088, 1'b1, 32'h0000_00A5});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 9'h0FF, 32'h0000_0000, 1'b0, 32'h0000_0077});

    repeat (3) @(negedge clk);
    check("reset rdata a", rdata_a, 32'h0);
    check("reset busy a", 32'(busy_a), 32'h0);
    check("reset ready a", 32'(ready_a), 32'h0);
    check("reset err a", 32'(err_a), 32'h0);
    check("reset rdata b", rdata_b, 32'h0);
    check("reset busy b", 32'(busy_b), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].s, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b1, tbl[i].x_err, tbl[i].x_rdata);
    end

    // Reset while the 1-wait-state instance sits in WAIT.
    @(negedge clk);
    sel = 1'b0; rd = 1'b1; wr = 1'b0; addr = 9'h054;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("busy before reset", 32'(o_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid reset rdata", o_rdata, 32'h0);
    check("mid reset busy", 32'(o_busy), 32'h0);
    check("mid reset ready", 32'(o_ready), 32'h0);
    check("mid reset err", 32'(o_err), 32'h0);
    check("mid reset we", 32'(o_we), 32'h0);
    check("mid reset rdata b", rdata_b, 32'h0);
    rd = 1'b0;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 1'b1, 1'b0, 9'h054, 32'h0, 1'b1, 1'b0, 32'h0000_0097);

    // Back-to-back reads with zero wait states, request held throughout.
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; wr = 1'b0; addr = 9'h000;
    t1 = -1; t2 = -1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (o_ready) begin
        if (t1 < 0) begin
          t1 = n;
          check("b2b first rdata", o_rdata, mdl_mem[1][0]);
          addr = 9'h001;
        end else begin
          t2 = n;
          check("b2b second rdata", o_rdata, mdl_mem[1][1]);
          break;
        end
      end
    end
    rd = 1'b0;
    mdl_rdata[1] = mdl_mem[1][1];
    check("b2b first latency", 32'(t1), 32'd2);
    check("b2b pulse spacing", 32'(t2 - t1), 32'd3);
    @(negedge clk);

    // Randomized traffic against the model, over a pre-written address pool.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        run_op(1'(s), 1'b0, 1'b1, 9'(k * 36), $urandom, 1'b0, 1'b0, 32'h0);
      end
    end
    for (int i = 0; i < 150; i++) begin
      bit s, r, w;
      logic [8:0] a;
      int k;
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 9'($urandom_range(depth_of(s), 511));
      else a = 9'($urandom_range(0, 7) * 36);
      k = $urandom_range(0, 9);
      r = (k == 0) || (k >= 5);
      w = (k <= 4);
      run_op(s, r, w, a, $urandom, 1'b0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
